// File: rtl/ecg_nn_pkg.sv
// Shared types and constants for the ECG network output stage.
// Holds the argmax FSM state encoding, the score width and the class-width helper.
package ecg_nn_pkg;

    localparam int SCORE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CAPTURE,
        SCAN,
        DONE
    } argmax_state_t;

    // A single-class layer still needs a one-bit index.
    function automatic int class_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/argmax_step.sv
// One compare-and-select step of the running maximum search.
// The compare is strictly greater-than, so the earliest index wins when scores tie.
module argmax_step
    import ecg_nn_pkg::*;
#(
    parameter int CLASS_W = 5
) (
    input  logic [SCORE_W-1:0] best,
    input  logic [CLASS_W-1:0] best_idx,
    input  logic [SCORE_W-1:0] elem,
    input  logic [CLASS_W-1:0] idx,
    output logic [SCORE_W-1:0] new_best,
    output logic [CLASS_W-1:0] new_idx
);

    always_comb begin
        new_best = best;
        new_idx  = best_idx;
        if (elem > best) begin
            new_best = elem;
            new_idx  = idx;
        end
    end

endmodule

// File: rtl/layer_argmax.sv
// Output-stage classifier: captures the final layer after a fixed latency, scans
// the scores one per cycle and presents the winning class on a valid/ready port.
module layer_argmax
    import ecg_nn_pkg::*;
#(
    parameter int N_IN    = 32,
    parameter int LAT     = 3,
    parameter int CLASS_W = class_width(N_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_start,
    input  logic [8*N_IN-1:0]       layer_bus,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [CLASS_W-1:0]      out_class,
    output logic [SCORE_W-1:0]      out_score,
    output logic                    busy,
    output logic                    overrun
);

    localparam logic [3:0]         WAIT_LOAD = 4'(LAT - 1);
    localparam logic [CLASS_W-1:0] LAST_IDX  = CLASS_W'(N_IN - 1);

    argmax_state_t state_reg, state_next;
    logic [3:0]         wait_cnt_reg, wait_cnt_next;
    logic [CLASS_W-1:0] scan_idx_reg, scan_idx_next;
    logic [CLASS_W-1:0] best_idx_reg, best_idx_next;
    logic [SCORE_W-1:0] best_reg, best_next;
    logic [CLASS_W-1:0] out_class_reg, out_class_next;
    logic [SCORE_W-1:0] out_score_reg, out_score_next;
    logic               overrun_reg, overrun_next;

    logic [SCORE_W-1:0] bus_elem [N_IN];
    logic [SCORE_W-1:0] cap_reg  [N_IN];
    logic [SCORE_W-1:0] step_best;
    logic [CLASS_W-1:0] step_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_unpack
            assign bus_elem[gi] = layer_bus[gi*SCORE_W +: SCORE_W];
        end
    endgenerate

    // The whole layer is frozen in one cycle; the bus is free to change afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++) cap_reg[i] <= '0;
        end else if (state_reg == CAPTURE) begin
            for (int i = 0; i < N_IN; i++) cap_reg[i] <= bus_elem[i];
        end
    end

    argmax_step #(
        .CLASS_W (CLASS_W)
    ) u_step (
        .best     (best_reg),
        .best_idx (best_idx_reg),
        .elem     (cap_reg[scan_idx_reg]),
        .idx      (scan_idx_reg),
        .new_best (step_best),
        .new_idx  (step_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            scan_idx_reg  <= '0;
            best_idx_reg  <= '0;
            best_reg      <= '0;
            out_class_reg <= '0;
            out_score_reg <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            scan_idx_reg  <= scan_idx_next;
            best_idx_reg  <= best_idx_next;
            best_reg      <= best_next;
            out_class_reg <= out_class_next;
            out_score_reg <= out_score_next;
            overrun_reg   <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        scan_idx_next  = scan_idx_reg;
        best_idx_next  = best_idx_reg;
        best_next      = best_reg;
        out_class_next = out_class_reg;
        out_score_next = out_score_reg;
        overrun_next   = overrun_reg;

        case (state_reg)
            IDLE: begin
                if (in_start) begin
                    // With a one-cycle latency the capture edge follows the start edge directly.
                    state_next    = (LAT == 1) ? CAPTURE : WAIT;
                    wait_cnt_next = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (in_start) overrun_next = 1'b1;
                if (wait_cnt_reg <= 4'd1) begin
                    state_next    = CAPTURE;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            CAPTURE: begin
                if (in_start) overrun_next = 1'b1;
                best_next     = bus_elem[0];
                best_idx_next = '0;
                scan_idx_next = CLASS_W'(1);
                state_next    = SCAN;
            end
            SCAN: begin
                if (in_start) overrun_next = 1'b1;
                best_next     = step_best;
                best_idx_next = step_idx;
                if (scan_idx_reg == LAST_IDX) begin
                    state_next     = DONE;
                    out_class_next = step_idx;
                    out_score_next = step_best;
                    scan_idx_next  = '0;
                end else begin
                    scan_idx_next = scan_idx_reg + CLASS_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_start) begin
                        state_next    = (LAT == 1) ? CAPTURE : WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (in_start) begin
                    overrun_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out_class = out_class_reg;
    assign out_score = out_score_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_layer_argmax.sv
// Directed bench for layer_argmax with N_IN=4, LAT=3; expected results are
// queued when a start pulse is driven and compared when out_valid rises.
module tb_layer_argmax;

    localparam int N_IN = 4;
    localparam int LAT  = 3;
    localparam int CW   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_start;
    logic [8*N_IN-1:0] layer_bus;
    logic              out_ready;
    logic              out_valid;
    logic [CW-1:0]     out_class;
    logic [7:0]        out_score;
    logic              busy;
    logic              overrun;

    typedef struct {
        logic [CW-1:0] cls;
        logic [7:0]    score;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    layer_argmax #(
        .N_IN (N_IN),
        .LAT  (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_start  (in_start),
        .layer_bus (layer_bus),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_class (out_class),
        .out_score (out_score),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start pulse; the edge inside is E0.
    task automatic pulse(input logic [CW-1:0] cls, input logic [7:0] score, input bit push);
        exp_t e;
        e.cls   = cls;
        e.score = score;
        if (push) sb_q.push_back(e);
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
    endtask

    // Waits for out_valid starting #1 after E0; optionally scrambles the bus on
    // every edge except the capture edge, where cap_val is presented.
    task automatic wait_result(input string tag, input bit scramble, input logic [31:0] cap_val);
        int   cyc;
        exp_t e;
        logic [31:0] rb;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            if (scramble) begin
                rb = $urandom;
                rb[7:0] = 8'hFF;
                layer_bus = (cyc == LAT - 1) ? cap_val : rb;
            end
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, LAT + N_IN - 1);
        check({tag, "_sb_nonempty"}, (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_class"}, out_class, e.cls);
            check({tag, "_score"}, out_score, e.score);
            $display("txn %s class=%0d score=%0d latency=%0d", tag, out_class, out_score, cyc);
        end
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_busy_drop"}, busy, 0);
    endtask

    task automatic run(input string tag, input logic [31:0] bus, input logic [CW-1:0] cls,
                       input logic [7:0] score);
        layer_bus = bus;
        pulse(cls, score, 1'b1);
        check({tag, "_busy"}, busy, 1);
        wait_result(tag, 1'b0, 32'h0);
        accept(tag);
    endtask

    initial begin
        logic [CW-1:0] held_cls;
        logic [7:0]    held_score;
        int            valid_seen;

        reset     = 1'b1;
        in_start  = 1'b0;
        out_ready = 1'b0;
        layer_bus = '0;
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_class", out_class, 0);
        check("rst_score", out_score, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        tick();

        // Bus packing is {node3, node2, node1, node0}.
        run("basic",  {8'd7,   8'd45, 8'd90,  8'd10},  2'd1, 8'd90);
        run("ties",   {8'd128, 8'd3,  8'd128, 8'd128}, 2'd0, 8'd128);
        run("zeros",  32'h0,                           2'd0, 8'd0);
        run("last",   {8'd5,   8'd0,  8'd0,   8'd0},   2'd3, 8'd5);
        check("overrun_clear", overrun, 0);

        // Backpressure with bus noise and a dropped start during DONE.
        layer_bus = {8'd1, 8'd60, 8'd60, 8'd20};
        pulse(2'd1, 8'd60, 1'b1);
        wait_result("hold", 1'b0, 32'h0);
        held_cls   = out_class;
        held_score = out_score;
        for (int k = 0; k < 10; k++) begin
            layer_bus = $urandom;
            in_start  = (k == 3);
            tick();
            in_start  = 1'b0;
            check("hold_valid", out_valid, 1);
            check("hold_class", out_class, held_cls);
            check("hold_score", out_score, held_score);
        end
        check("hold_overrun", overrun, 1);

        // Accept and restart on the same edge.
        layer_bus = {8'd200, 8'd7, 8'd6, 8'd5};
        sb_q.push_back('{cls: 2'd3, score: 8'd200});
        out_ready = 1'b1;
        in_start  = 1'b1;
        tick();
        out_ready = 1'b0;
        in_start  = 1'b0;
        check("restart_valid_drop", out_valid, 0);
        check("restart_busy", busy, 1);
        wait_result("restart", 1'b0, 32'h0);
        check("restart_overrun_sticky", overrun, 1);
        accept("restart");

        // Asynchronous reset in the middle of the scan.
        layer_bus = {8'd9, 8'd8, 8'd77, 8'd6};
        pulse(2'd1, 8'd77, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        check("midscan_busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", out_valid, 0);
        check("async_class", out_class, 0);
        check("async_score", out_score, 0);
        check("async_busy", busy, 0);
        check("async_overrun", overrun, 0);
        sb_q.delete();
        tick();
        reset = 1'b0;
        valid_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid !== 1'b0) valid_seen++;
        end
        check("post_reset_quiet", valid_seen, 0);

        // Bus changes every cycle; only the capture-edge value may matter.
        layer_bus = 32'hFFFF_FFFF;
        pulse(2'd1, 8'd99, 1'b1);
        wait_result("scramble", 1'b1, {8'd99, 8'd12, 8'd99, 8'd33});
        accept("scramble");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_argmax.md
# layer_argmax

Output-stage classifier that sits directly downstream of the final dense layer's node array. It watches for a start pulse, waits the fixed node pipeline latency, and captures all node outputs in one cycle. It then scans them sequentially to find the highest score and presents the winning class index and score on a valid/ready interface to the system controller.

## Interface
Parameters:
- N_IN, 32, number of node outputs (classes) in the consumed layer; legal range 2..256.
- LAT, 3, cycles from the `in_start` sampling edge to the edge at which node outputs are valid; legal range 1..15.
- CLASS_W, $clog2(N_IN), width of the class index.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_start  in  1  single-cycle pulse, co-timed with the edge at which the layer's inputs are applied.
- layer_bus  in  8*N_IN  packed node outputs, unsigned; node k occupies bits [8k+7:8k].
- out_ready  in  1  consumer accepts the result.
- out_valid  out  1  result held stable while high.
- out_class  out  CLASS_W  index of the maximum score.
- out_score  out  8  maximum score, unsigned.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky flag: an `in_start` pulse was dropped.

## Operation
- Scores are 8-bit unsigned. The node saturation and rounding path can yield 0..128, so all compares are full 8-bit unsigned compares, never signed.
- FSM states: IDLE, WAIT, CAPTURE, SCAN, DONE.
  - IDLE: `in_start`=1 → WAIT, load wait counter.
  - WAIT: count down the LAT-1 remaining cycles → CAPTURE.
  - CAPTURE: register all of `layer_bus` into a capture array. Seed best=element 0, best_idx=0, scan_idx=1 → SCAN.
  - SCAN: one element per cycle. If elem[scan_idx] > best, update best and best_idx. Leave SCAN after scan_idx=N_IN-1 is processed → DONE.
  - DONE: `out_valid`=1. When `out_valid`&&`out_ready` → IDLE, or → WAIT directly if `in_start`=1 on the same edge.
- Tie-break: strict greater-than, so the lowest index wins among equal maxima.
- `in_start` seen in WAIT, CAPTURE, SCAN, or DONE without acceptance:
  - The pulse is ignored and `overrun` is set.
  - `overrun` clears only on reset.
- `layer_bus` is sampled only in CAPTURE. Changes at any other time have no effect.
- `out_class` and `out_score` update only on the DONE entry edge and hold otherwise.

## Timing
- Reset values: out_valid=0, out_class=0, out_score=0, busy=0, overrun=0, FSM=IDLE, counters=0, capture array=0.
- Reset asserted mid-operation aborts immediately. No result is emitted after reset release.
- Edge E0 samples `in_start`:
  - Capture occurs at edge E0+LAT.
  - `out_valid` rises after edge E0+LAT+N_IN-1, i.e. it is visible in the cycle following that edge. Total latency is LAT+N_IN cycles.
- `busy` rises after E0 and falls after the accept edge, unless it is immediately restarted.
- The accept edge drops `out_valid` the next cycle. Back-to-back results are therefore separated by at least one cycle of `out_valid`=0.
- `out_ready` is ignored when `out_valid`=0.

## Structure
- Shared package `ecg_nn_pkg`:
  - state enum `argmax_state_t` {IDLE, WAIT, CAPTURE, SCAN, DONE};
  - `SCORE_W`=8 constant;
  - class-width helper function.
- One natural sub-module, `argmax_step`: combinational compare-and-select of (best, best_idx) against (elem, idx), producing the updated pair. The FSM, counters, and capture array live in `layer_argmax`.

## Test plan
- N_IN=4, LAT=3, scores {10,90,45,7}, pulse at E0 → `out_valid` after E0+6 with class=1, score=90; `out_ready`=1 → `out_valid`=0 next cycle and `busy`=0.
- Ties: {128,128,3,128} → class=0, score=128. This verifies unsigned compare and lowest-index tie-break.
- All zeros → class=0, score=0. Separately, {0,0,0,5} → class=3, score=5, exercising the final scan element.
- Hold `out_ready`=0 for 10 cycles, toggle `layer_bus`, and pulse `in_start` during DONE:
  - outputs stay constant and `overrun`=1;
  - on the later accept with `in_start`=1 on the same edge, the FSM goes directly to WAIT and the second result arrives LAT+N_IN cycles later.
- Assert `reset` asynchronously mid-SCAN (between edges) → all outputs 0 immediately. After release with no new pulse, `out_valid` stays 0 for 20 cycles.
- Change `layer_bus` on every cycle except the capture edge → result reflects only the value present at edge E0+LAT.
